// File: rtl/mem_load_align.sv
// mem_load_align: load-return path that tracks outstanding loads, aligns and extends returned words, and buffers results for writeback
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             load issue handshake; req_func3, req_byte_addr, req_rd describe the load
//   mem_rsp_valid, mem_rdata        in-order raw read word from memory (cannot be stalled)
//   wb_valid/wb_ready               writeback handshake; wb_data, wb_rd carry the extended result
//   err                             sticky: response with nothing pending, or illegal funct3
module mem_load_align #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_WIDTH = 5,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_func3,
  input  logic [1:0]            req_byte_addr,
  input  logic [RD_WIDTH-1:0]   req_rd,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic [RD_WIDTH-1:0]   wb_rd,
  output logic                  err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [AW:0] cnt, mwp, mrp, rwp, rrp;
  logic [2:0] m_f3 [DEPTH];
  logic [1:0] m_off [DEPTH];
  logic [RD_WIDTH-1:0] m_rd [DEPTH];
  logic [RD_WIDTH-1:0] r_rd [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic acc, hs, rsp_ok, illegal;
  logic [2:0] h_f3;
  logic [1:0] h_off;
  logic [DATA_WIDTH-1:0] sh_b, sh_h, aligned;
  logic [7:0] b;
  logic [15:0] h;
  assign req_ready = cnt < FULL;
  assign acc = req_valid && req_ready;
  assign wb_valid = rwp != rrp;
  assign hs = wb_valid && wb_ready;
  // The meta head is sampled before this cycle's push, so a same-cycle request never pairs with the response
  assign rsp_ok = mem_rsp_valid && (mwp != mrp);
  assign illegal = (req_func3 == 3'b011) || (req_func3[2:1] == 2'b11);
  assign h_f3 = m_f3[mrp[AW-1:0]];
  assign h_off = m_off[mrp[AW-1:0]];
  assign sh_b = mem_rdata >> {h_off, 3'b000};
  // Half-word offsets round down to an even byte, as on the store side
  assign sh_h = mem_rdata >> {h_off[1], 4'b0000};
  assign b = sh_b[7:0];
  assign h = sh_h[15:0];
  // funct3[1] covers LW and every illegal code, all of which return the raw word
  always_comb
    aligned = h_f3[1] ? mem_rdata
            : h_f3[0] ? {{16{h[15] & ~h_f3[2]}}, h}
            : {{24{b[7] & ~h_f3[2]}}, b};
  assign wb_data = wb_valid ? r_data[rrp[AW-1:0]] : '0;
  assign wb_rd = wb_valid ? r_rd[rrp[AW-1:0]] : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      mwp <= '0;
      mrp <= '0;
      rwp <= '0;
      rrp <= '0;
      err <= 1'b0;
    end else begin
      cnt <= cnt + (acc ? ONE : '0) - (hs ? ONE : '0);
      if (acc) mwp <= mwp + ONE;
      if (rsp_ok) mrp <= mrp + ONE;
      if (rsp_ok) rwp <= rwp + ONE;
      if (hs) rrp <= rrp + ONE;
      if ((acc && illegal) || (mem_rsp_valid && !rsp_ok)) err <= 1'b1;
    end
  always_ff @(posedge clk) begin
    if (acc) begin
      m_f3[mwp[AW-1:0]] <= req_func3;
      m_off[mwp[AW-1:0]] <= req_byte_addr;
      m_rd[mwp[AW-1:0]] <= req_rd;
    end
    if (rsp_ok) begin
      r_data[rwp[AW-1:0]] <= aligned;
      r_rd[rwp[AW-1:0]] <= m_rd[mrp[AW-1:0]];
    end
  end
endmodule
